// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// default operand width and the quotient reported on divide-by-zero.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    // Wide enough for any supported width; the divider slices off its own N bits.
    localparam logic [63:0] DBZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem,quo} left, trial
// subtract the divisor, keep the difference only when it does not borrow.
module div_step
    import div_pkg::*;
#(
    parameter int N = DIV_WIDTH
) (
    input  logic [N-1:0] i_rem,
    input  logic [N-1:0] i_quo,
    input  logic [N-1:0] i_divisor,
    output logic [N-1:0] o_rem,
    output logic [N-1:0] o_quo
);

    logic [N:0]   w_shift_rem;
    logic [N+1:0] w_diff;
    logic         w_borrow;

    // The shifted remainder needs N+1 bits, so an extra top bit carries the borrow.
    assign w_shift_rem = {i_rem, i_quo[N-1]};
    assign w_diff      = {1'b0, w_shift_rem} - {2'b00, i_divisor};
    assign w_borrow    = w_diff[N+1];

    // Whichever value is kept is below the divisor, so it fits in N bits.
    assign o_rem = N'(w_borrow ? w_shift_rem : w_diff[N:0]);
    assign o_quo = {i_quo[N-2:0], ~w_borrow};

endmodule

// File: rtl/div32_seq.sv
// Sequential N-bit restoring divider, one quotient bit per cycle.
// Define DIV32_SEQ_SIGNED_EN to add the sgn input for two's-complement division.
module div32_seq
    import div_pkg::*;
#(
    parameter int N = DIV_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
`ifdef DIV32_SEQ_SIGNED_EN
    input  logic         sgn,
`endif
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N + 1);

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic [N-1:0]  r_rem;
    logic [N-1:0]  r_quo;
    logic [N-1:0]  r_divisor;
    logic          r_dbz;
    logic          r_neg_q;
    logic          r_neg_r;
    logic          r_busy;
    logic          r_done;
    logic [N-1:0]  r_quotient;
    logic [N-1:0]  r_remainder;
    logic          r_div_by_zero;

    logic [N-1:0]  w_rem_next;
    logic [N-1:0]  w_quo_next;
    logic [N-1:0]  w_op_a;
    logic [N-1:0]  w_op_b;
    logic          w_neg_q;
    logic          w_neg_r;

`ifdef DIV32_SEQ_SIGNED_EN
    logic w_a_neg;
    logic w_b_neg;

    // Divide magnitudes; the signs are reapplied to the results in FIN.
    assign w_a_neg = sgn & dividend[N-1];
    assign w_b_neg = sgn & divisor[N-1];
    assign w_op_a  = w_a_neg ? -dividend : dividend;
    assign w_op_b  = w_b_neg ? -divisor  : divisor;
    assign w_neg_q = w_a_neg ^ w_b_neg;
    assign w_neg_r = w_a_neg;
`else
    assign w_op_a  = dividend;
    assign w_op_b  = divisor;
    assign w_neg_q = 1'b0;
    assign w_neg_r = 1'b0;
`endif

    div_step #(
        .N(N)
    ) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_next),
        .o_quo     (w_quo_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_divisor     <= '0;
            r_dbz         <= 1'b0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_quo     <= w_op_a;
                        r_divisor <= w_op_b;
                        r_neg_q   <= w_neg_q;
                        r_neg_r   <= w_neg_r;
                        if (divisor == '0) begin
                            // Park the raw dividend; it is reported as the remainder.
                            r_rem   <= dividend;
                            r_dbz   <= 1'b1;
                            r_count <= '0;
                            r_state <= FIN;
                        end else begin
                            r_rem   <= '0;
                            r_dbz   <= 1'b0;
                            r_count <= CW'(N);
                            r_busy  <= 1'b1;
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_count <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        r_busy  <= 1'b0;
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                    if (r_dbz) begin
                        r_quotient    <= DBZ_QUOTIENT[N-1:0];
                        r_remainder   <= r_rem;
                        r_div_by_zero <= 1'b1;
                    end else begin
                        r_quotient    <= r_neg_q ? -r_quo : r_quo;
                        r_remainder   <= r_neg_r ? -r_rem : r_rem;
                        r_div_by_zero <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_div32_seq.sv
// Directed self-checking bench for div32_seq; the signed scenarios are
// included when DIV32_SEQ_SIGNED_EN is defined.
module tb_div32_seq;

    localparam int N = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
`ifdef DIV32_SEQ_SIGNED_EN
    logic         sgn;
`endif
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int n_vec = 0;
    int n_err = 0;

    div32_seq #(
        .N(N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef DIV32_SEQ_SIGNED_EN
        .sgn         (sgn),
`endif
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start so that the next rising edge accepts it (cycle 0).
    task automatic do_start(input logic [N-1:0] a, input logic [N-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Cycles from the accept edge to the edge that raises done; -1 on timeout.
    task automatic wait_done(input int max, output int lat);
        lat = -1;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
        n_vec++; if (quotient !== 32'h0) begin n_err++; $display("FAIL reset_q got %h exp 0", quotient); end
        n_vec++; if (remainder !== 32'h0) begin n_err++; $display("FAIL reset_r got %h exp 0", remainder); end
        n_vec++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz got %b exp 0", div_by_zero); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int lat;
        do_start(32'd100, 32'd7);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got %b exp 1", busy); end
        wait_done(40, lat);
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL basic_latency got %0d exp 33", lat); end
        n_vec++; if (quotient !== 32'd14) begin n_err++; $display("FAIL basic_q got %h exp %h", quotient, 32'd14); end
        n_vec++; if (remainder !== 32'd2) begin n_err++; $display("FAIL basic_r got %h exp %h", remainder, 32'd2); end
        n_vec++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL basic_dbz got %b exp 0", div_by_zero); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_done got %b exp 0", busy); end
        @(posedge clk);
        #1;
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_width got %b exp 0", done); end
        n_vec++; if (quotient !== 32'd14) begin n_err++; $display("FAIL basic_q_hold got %h exp %h", quotient, 32'd14); end
        do_start(32'd0, 32'd5);
        wait_done(40, lat);
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL zero_num_latency got %0d exp 33", lat); end
        n_vec++; if (quotient !== 32'd0) begin n_err++; $display("FAIL zero_num_q got %h exp 0", quotient); end
        n_vec++; if (remainder !== 32'd0) begin n_err++; $display("FAIL zero_num_r got %h exp 0", remainder); end
    endtask

    task automatic test_div_by_zero();
        int lat;
        do_start(32'd5, 32'd0);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL dbz_busy got %b exp 0", busy); end
        wait_done(40, lat);
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL dbz_latency got %0d exp 1", lat); end
        n_vec++; if (quotient !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dbz_q got %h exp ffffffff", quotient); end
        n_vec++; if (remainder !== 32'd5) begin n_err++; $display("FAIL dbz_r got %h exp 5", remainder); end
        n_vec++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dbz_flag got %b exp 1", div_by_zero); end
        @(posedge clk);
        #1;
        n_vec++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dbz_flag_hold got %b exp 1", div_by_zero); end
    endtask

    task automatic test_ignore_start();
        int lat = -1;
        int n_done = 0;
        do_start(32'hFFFF_FFFF, 32'd1);
        for (int i = 1; i <= 40; i++) begin
            start = (i == 10);
            if (i == 10) begin
                dividend = 32'd9;
                divisor  = 32'd3;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (i == 10) begin
                n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL ignore_busy got %b exp 1", busy); end
            end
            if (done) begin
                n_done++;
                if (lat < 0) lat = i;
            end
        end
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL ignore_latency got %0d exp 33", lat); end
        n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL ignore_done_count got %0d exp 1", n_done); end
        n_vec++; if (quotient !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL ignore_q got %h exp ffffffff", quotient); end
        n_vec++; if (remainder !== 32'd0) begin n_err++; $display("FAIL ignore_r got %h exp 0", remainder); end
    endtask

    task automatic test_reset_abort();
        int lat;
        logic saw_done = 1'b0;
        do_start(32'd1000, 32'd10);
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk);
            #1;
            saw_done |= done;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b exp 0", busy); end
        n_vec++; if (quotient !== 32'd0) begin n_err++; $display("FAIL abort_q got %h exp 0", quotient); end
        n_vec++; if (remainder !== 32'd0) begin n_err++; $display("FAIL abort_r got %h exp 0", remainder); end
        n_vec++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL abort_dbz got %b exp 0", div_by_zero); end
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            saw_done |= done;
        end
        n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL abort_no_done got %b exp 0", saw_done); end
        do_start(32'd9, 32'd4);
        wait_done(40, lat);
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL abort_restart_latency got %0d exp 33", lat); end
        n_vec++; if (quotient !== 32'd2) begin n_err++; $display("FAIL abort_restart_q got %h exp 2", quotient); end
        n_vec++; if (remainder !== 32'd1) begin n_err++; $display("FAIL abort_restart_r got %h exp 1", remainder); end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_start(32'd1000, 32'd33);
        wait_done(40, lat);
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL b2b_first_latency got %0d exp 33", lat); end
        n_vec++; if (quotient !== 32'd30) begin n_err++; $display("FAIL b2b_first_q got %h exp %h", quotient, 32'd30); end
        n_vec++; if (remainder !== 32'd10) begin n_err++; $display("FAIL b2b_first_r got %h exp %h", remainder, 32'd10); end
        // Start in the cycle right after done.
        do_start(32'hFFFF_FFFF, 32'd16);
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_width got %b exp 0", done); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept_busy got %b exp 1", busy); end
        wait_done(40, lat);
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL b2b_second_latency got %0d exp 33", lat); end
        n_vec++; if (quotient !== 32'h0FFF_FFFF) begin n_err++; $display("FAIL b2b_second_q got %h exp 0fffffff", quotient); end
        n_vec++; if (remainder !== 32'hF) begin n_err++; $display("FAIL b2b_second_r got %h exp f", remainder); end
    endtask

`ifdef DIV32_SEQ_SIGNED_EN
    task automatic test_signed();
        int lat;
        sgn = 1'b1;
        do_start(32'hFFFF_FFF9, 32'd2);
        wait_done(40, lat);
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL signed_latency got %0d exp 33", lat); end
        n_vec++; if (quotient !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL signed_m7d2_q got %h exp fffffffd", quotient); end
        n_vec++; if (remainder !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL signed_m7d2_r got %h exp ffffffff", remainder); end
        do_start(32'd7, 32'hFFFF_FFFE);
        wait_done(40, lat);
        n_vec++; if (quotient !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL signed_7dm2_q got %h exp fffffffd", quotient); end
        n_vec++; if (remainder !== 32'd1) begin n_err++; $display("FAIL signed_7dm2_r got %h exp 1", remainder); end
        do_start(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(40, lat);
        n_vec++; if (quotient !== 32'h8000_0000) begin n_err++; $display("FAIL signed_minm1_q got %h exp 80000000", quotient); end
        n_vec++; if (remainder !== 32'd0) begin n_err++; $display("FAIL signed_minm1_r got %h exp 0", remainder); end
        do_start(32'hFFFF_FFF9, 32'd0);
        wait_done(40, lat);
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL signed_dbz_latency got %0d exp 1", lat); end
        n_vec++; if (quotient !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL signed_dbz_q got %h exp ffffffff", quotient); end
        n_vec++; if (remainder !== 32'hFFFF_FFF9) begin n_err++; $display("FAIL signed_dbz_r got %h exp fffffff9", remainder); end
        sgn = 1'b0;
        do_start(32'hFFFF_FFF9, 32'd2);
        wait_done(40, lat);
        n_vec++; if (quotient !== 32'h7FFF_FFFC) begin n_err++; $display("FAIL unsigned_mode_q got %h exp 7ffffffc", quotient); end
        n_vec++; if (remainder !== 32'd1) begin n_err++; $display("FAIL unsigned_mode_r got %h exp 1", remainder); end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
`ifdef DIV32_SEQ_SIGNED_EN
        sgn      = 1'b0;
`endif
        test_reset();
        test_basic();
        test_div_by_zero();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
`ifdef DIV32_SEQ_SIGNED_EN
        test_signed();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
